// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-byte sequencer: E0/F0 prefix tracking, 4-entry event FIFO, arrow held-state and
// x position. Define KEY_REPEAT_EN to build the held-arrow auto-repeat counter.
module ps2_key_event_ctrl #(
    parameter int unsigned      POS_W          = 9,
    parameter logic [POS_W-1:0] X_INIT         = 9'd160,
    parameter logic [POS_W-1:0] X_MIN          = 9'd0,
    parameter logic [POS_W-1:0] X_MAX          = 9'd310,
    parameter logic [POS_W-1:0] STEP           = 9'd10,
    parameter int unsigned      PREFIX_TIMEOUT = 50000,
    parameter int unsigned      REPEAT_CYCLES  = 2500000,
    parameter bit               ARROW_REQ_EXT  = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic             byte_err,
    output logic             evt_valid,
    output logic [9:0]       evt_data,
    input  logic             evt_ready,
    output logic             evt_overflow,
    output logic [7:0]       err_count,
    output logic             left_held,
    output logic             right_held,
    output logic [POS_W-1:0] x_pos
);

    localparam int unsigned TMR_W = $clog2(PREFIX_TIMEOUT + 1);
    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  CODE_EXT   = 8'hE0;
    localparam logic [7:0]  CODE_BRK   = 8'hF0;
    localparam logic [7:0]  CODE_LEFT  = 8'h6B;
    localparam logic [7:0]  CODE_RIGHT = 8'h74;

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             emit;
    logic [9:0]       emit_data;
    logic             err_inc;
    logic             is_prefix;

    assign is_prefix = (byte_data == CODE_EXT) || (byte_data == CODE_BRK);

    // Prefix sequencer
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        emit      = 1'b0;
        emit_data = {2'b00, byte_data};
        err_inc   = 1'b0;
        if (byte_valid) begin
            tmr_d = '0;
            if (byte_err) begin
                state_d = StIdle;
                err_inc = 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (byte_data == CODE_EXT) begin
                            state_d = StExt;
                        end else if (byte_data == CODE_BRK) begin
                            state_d = StBrk;
                        end else begin
                            emit = 1'b1;
                        end
                    end
                    StExt: begin
                        if (byte_data == CODE_BRK) begin
                            state_d = StExtBrk;
                        end else if (byte_data != CODE_EXT) begin
                            emit      = 1'b1;
                            emit_data = {2'b10, byte_data};
                            state_d   = StIdle;
                        end
                    end
                    StBrk: begin
                        state_d   = StIdle;
                        emit      = !is_prefix;
                        emit_data = {2'b01, byte_data};
                    end
                    StExtBrk: begin
                        state_d   = StIdle;
                        emit      = !is_prefix;
                        emit_data = {2'b11, byte_data};
                    end
                    default: state_d = StIdle;
                endcase
            end
        end else if (state_q != StIdle) begin
            if (tmr_q == TMR_W'(PREFIX_TIMEOUT - 1)) begin
                state_d = StIdle;
                tmr_d   = '0;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            tmr_q     <= '0;
            err_count <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            if (err_inc && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    // Event FIFO: a push on a full FIFO is kept only if the head pops in the same cycle
    logic [9:0] mem_q [DEPTH];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] cnt_q;
    logic       full, push, pop, drop;

    assign full      = (cnt_q == 3'(DEPTH));
    assign evt_valid = (cnt_q != 3'd0);
    assign pop       = evt_valid && evt_ready;
    assign push      = emit && (!full || pop);
    assign drop      = emit && full && !pop;
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : 10'd0;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= emit_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
            if (drop) begin
                evt_overflow <= 1'b1;
            end
        end
    end

    // Arrow tracking acts on every emitted event, dropped or not
    logic left_evt, right_evt, left_make, right_make, ext_ok;
    logic left_held_d, right_held_d;
    logic mv_left, mv_right;

    assign ext_ok       = !ARROW_REQ_EXT || emit_data[9];
    assign left_evt     = emit && ext_ok && (emit_data[7:0] == CODE_LEFT);
    assign right_evt    = emit && ext_ok && (emit_data[7:0] == CODE_RIGHT);
    assign left_make    = left_evt && !emit_data[8];
    assign right_make   = right_evt && !emit_data[8];
    assign left_held_d  = left_evt ? !emit_data[8] : left_held;
    assign right_held_d = right_evt ? !emit_data[8] : right_held;

`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             held_chg, one_held, rep_last, rep_tick;

    assign held_chg = (left_held_d != left_held) || (right_held_d != right_held);
    assign one_held = left_held ^ right_held;
    assign rep_last = (rep_cnt_q == REP_W'(REPEAT_CYCLES - 1));
    assign rep_tick = one_held && !held_chg && rep_last;

    always_comb begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
        if (held_chg || !one_held || rep_last) begin
            rep_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end

    // Typematic makes of an already-held arrow only keep the held flag alive
    assign mv_left  = (left_make && !left_held) || (rep_tick && left_held);
    assign mv_right = (right_make && !right_held) || (rep_tick && right_held);
`else
    // The repeat period only matters when auto-repeat is built in
    localparam int unsigned unused_repeat_cycles = REPEAT_CYCLES;

    assign mv_left  = left_make;
    assign mv_right = right_make;
`endif

    // Saturating moves in POS_W+1 bits so neither bound can wrap
    logic [POS_W:0]   x_wide, lo_lim, x_sub, x_add;
    logic [POS_W-1:0] x_d;

    assign x_wide = {1'b0, x_pos};
    assign lo_lim = {1'b0, X_MIN} + {1'b0, STEP};
    assign x_sub  = x_wide - {1'b0, STEP};
    assign x_add  = x_wide + {1'b0, STEP};

    always_comb begin
        x_d = x_pos;
        if (mv_left && !mv_right) begin
            x_d = (x_wide < lo_lim) ? X_MIN : x_sub[POS_W-1:0];
        end else if (mv_right && !mv_left) begin
            x_d = (x_add > {1'b0, X_MAX}) ? X_MAX : x_add[POS_W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            left_held  <= 1'b0;
            right_held <= 1'b0;
            x_pos      <= X_INIT;
        end else begin
            left_held  <= left_held_d;
            right_held <= right_held_d;
            x_pos      <= x_d;
        end
    end

endmodule
